// File: rtl/ifetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package ifetch_seq_pkg;

    localparam int IFS_AW_DEF      = 16;
    localparam int IFS_TIMEOUT_DEF = 15;

    localparam int IR_W   = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } ifs_state_t;

    // Registered IR request bundle. The low byte is loaded first with a
    // full-word write (upper lane zeroed); the high byte follows through the
    // upper-byte strobe, which takes din[7:0] into IR[15:8].
    typedef struct packed {
        logic [IR_W-1:0] din;
        logic            wr;
        logic            wru;
        logic            done;
    } ir_req_t;

    // Place a memory byte on the IR data lanes (low lane, upper lane zero).
    function automatic logic [IR_W-1:0] ir_lane(input logic [BYTE_W-1:0] b);
        return {{(IR_W-BYTE_W){1'b0}}, b};
    endfunction

endpackage

// File: rtl/ifetch_seq_bus_timer.sv
// Saturating wait-cycle counter; expired is high once TIMEOUT cycles have been counted.
// Latency: count advances one per enabled cycle, expired is a decode of the count.
// Backpressure: none; clear has priority over enable, count holds at TIMEOUT.
module ifetch_seq_bus_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt;

    assign expired = (cnt == TW'(TIMEOUT));

    // Count unacknowledged wait cycles, saturating at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + TW'(1);
        end
    end

endmodule

// File: rtl/ifetch_seq.sv
// Fetches a 16-bit instruction as two bytes (PC, PC+1) and loads them into the IR.
// Latency: zero-wait memory gives ir_write 2 cycles and ir_writeu/instr_done 3 cycles after start.
// Backpressure: holds mem_rd/mem_addr until mem_ack; branch aborts, timeout restarts at the instruction PC.
module ifetch_seq
    import ifetch_seq_pkg::*;
#(
    parameter int AW      = IFS_AW_DEF,
    parameter int TIMEOUT = IFS_TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          branch,
    input  logic [AW-1:0] branch_addr,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [7:0]    mem_data,
    output logic [15:0]   ir_din,
    output logic          ir_write,
    output logic          ir_writeu,
    output logic          instr_done,
    output logic          busy,
    output logic [AW-1:0] pc,
    output logic          bus_err
);

    ifs_state_t    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pc_start_q, pc_start_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] pc_inc;
    logic          rd_q, rd_d;
    logic          err_q, err_d;
    ir_req_t       ir_q, ir_d;
    logic          ack_v;
    logic          tmr_clr, tmr_en, tmr_exp;

    // An ack only counts while a read is actually outstanding.
    assign ack_v  = mem_ack & rd_q;
    assign pc_inc = pc_q + AW'(1);

    assign mem_rd     = rd_q;
    assign mem_addr   = addr_q;
    assign ir_din     = ir_q.din;
    assign ir_write   = ir_q.wr;
    assign ir_writeu  = ir_q.wru;
    assign instr_done = ir_q.done;
    assign bus_err    = err_q;
    assign busy       = (state_q != ST_IDLE);
    assign pc         = pc_q;

    // The expiry fires on the first unacked cycle after TIMEOUT waits were counted.
    ifetch_seq_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_exp)
    );

    // State, PC and all bus/IR outputs are registered; reset drops any fetch silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            pc_start_q <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            err_q      <= 1'b0;
            ir_q       <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_start_q <= pc_start_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            err_q      <= err_d;
            ir_q       <= ir_d;
        end
    end

    // Next-state logic: branch first, then ack, then timeout, then keep waiting.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_start_d = pc_start_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        err_d      = 1'b0;
        ir_d       = '{din: ir_q.din, wr: 1'b0, wru: 1'b0, done: 1'b0};
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;

        if (branch) begin
            // Redirect wins over everything; an ack seen now produces no strobe.
            pc_d    = branch_addr;
            rd_d    = 1'b0;
            state_d = ST_IDLE;
            tmr_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tmr_clr = 1'b1;
                    if (start) begin
                        pc_start_d = pc_q;
                        addr_d     = pc_q;
                        rd_d       = 1'b1;
                        state_d    = ST_LO;
                    end
                end
                ST_LO, ST_HI: begin
                    if (ack_v) begin
                        ir_d.din = ir_lane(mem_data);
                        pc_d     = pc_inc;
                        tmr_clr  = 1'b1;
                        if (state_q == ST_LO) begin
                            ir_d.wr = 1'b1;
                            addr_d  = pc_inc;
                            state_d = ST_HI;
                        end else begin
                            ir_d.wru  = 1'b1;
                            ir_d.done = 1'b1;
                            rd_d      = 1'b0;
                            state_d   = ST_IDLE;
                        end
                    end else if (tmr_exp) begin
                        // Abandon the instruction and rewind so it is refetched whole.
                        err_d   = 1'b1;
                        rd_d    = 1'b0;
                        pc_d    = pc_start_q;
                        state_d = ST_IDLE;
                        tmr_clr = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                default: begin
                    rd_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_seq.sv
// Self-checking bench for ifetch_seq: vector table, corner sequences, random run.
// Latency: checks fetch latency per vector against 3 + wait cycles.
// Backpressure: memory responder inserts queued or random wait states.
module tb_ifetch_seq;

    localparam int AW  = 16;
    localparam int TMO = 15;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          branch;
    logic [AW-1:0] branch_addr;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [7:0]    mem_data;
    logic [15:0]   ir_din;
    logic          ir_write;
    logic          ir_writeu;
    logic          instr_done;
    logic          busy;
    logic [AW-1:0] pc;
    logic          bus_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:65535];
    int         wq[$];
    bit         rnd_mode = 1'b0;

    // downstream IR image and strobe counters
    logic [15:0] ir_m;
    int nw    = 0;
    int nwu   = 0;
    int ndone = 0;

    // reference model state
    bit          m_act;
    int          m_nb;
    int          m_wait;
    logic [15:0] m_pc, m_start, e_addr, e_din;
    bit          e_w, e_wu, e_done, e_err;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  lo;
        logic [7:0]  hi;
        int          wlo;
        int          whi;
        logic [15:0] ir;
        logic [15:0] pc_after;
        int          lat;
    } vec_t;

    vec_t vt[6];

    ifetch_seq #(
        .AW      (AW),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .branch      (branch),
        .branch_addr (branch_addr),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .ir_din      (ir_din),
        .ir_write    (ir_write),
        .ir_writeu   (ir_writeu),
        .instr_done  (instr_done),
        .busy        (busy),
        .pc          (pc),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte memory: each new read request gets a wait count, then acks with mem[addr].
    initial begin
        int  cnt;
        int  cur;
        bit  newreq;
        cnt = 0; cur = 0; newreq = 1'b1;
        mem_ack = 1'b0; mem_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_rd) begin
                newreq = 1'b1;
                if (rnd_mode && $urandom_range(0, 3) == 0) begin
                    mem_ack  = 1'b1;
                    mem_data = 8'($urandom);
                end else begin
                    mem_ack = 1'b0;
                end
            end else begin
                if (newreq) begin
                    newreq = 1'b0;
                    cnt    = 0;
                    if (rnd_mode)
                        cur = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3))
                                                         : int'($urandom_range(0, TMO + 2));
                    else if (wq.size() > 0)
                        cur = wq.pop_front();
                    else
                        cur = 0;
                end
                if (cnt >= cur) begin
                    mem_ack  = 1'b1;
                    mem_data = mem[mem_addr];
                    newreq   = 1'b1;
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end
        end
    end

    // Reference model: a fetch is "active" with m_nb bytes delivered; address = start + m_nb.
    initial begin
        m_act = 1'b0; m_nb = 0; m_wait = 0; m_pc = '0; m_start = '0;
        e_addr = '0; e_din = '0; e_w = 1'b0; e_wu = 1'b0; e_done = 1'b0; e_err = 1'b0;
        ir_m = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_act = 1'b0; m_nb = 0; m_wait = 0; m_pc = '0; m_start = '0;
                e_addr = '0; e_din = '0; e_w = 1'b0; e_wu = 1'b0; e_done = 1'b0; e_err = 1'b0;
                ir_m = '0;
            end else begin
                if (ir_write)  begin ir_m = ir_din; nw++; end
                if (ir_writeu) begin ir_m[15:8] = ir_din[7:0]; nwu++; end
                if (instr_done) ndone++;

                chk("mdl_rd", mem_rd, m_act);
                chk("mdl_busy", busy, m_act);
                chk("mdl_pc", pc, m_pc);
                if (m_act) chk("mdl_addr", mem_addr, e_addr);
                chk("mdl_strobes", {ir_write, ir_writeu, instr_done, bus_err}, {e_w, e_wu, e_done, e_err});
                if (e_w || e_wu) chk("mdl_din", ir_din, e_din);

                e_w = 1'b0; e_wu = 1'b0; e_done = 1'b0; e_err = 1'b0;
                if (branch) begin
                    m_pc  = branch_addr;
                    m_act = 1'b0;
                end else if (!m_act) begin
                    if (start) begin
                        m_act   = 1'b1;
                        m_start = m_pc;
                        m_nb    = 0;
                        m_wait  = 0;
                        e_addr  = m_pc;
                    end
                end else if (mem_ack) begin
                    e_din = {8'h00, mem_data};
                    if (m_nb == 0) e_w = 1'b1;
                    else begin e_wu = 1'b1; e_done = 1'b1; end
                    m_nb++;
                    m_pc   = m_start + 16'(m_nb);
                    e_addr = m_pc;
                    m_wait = 0;
                    if (m_nb == 2) m_act = 1'b0;
                end else if (m_wait == TMO) begin
                    e_err = 1'b1;
                    m_act = 1'b0;
                    m_pc  = m_start;
                end else begin
                    m_wait++;
                end
            end
        end
    end

    initial begin
        int          lat;
        int          w0;
        int          u0;
        int          d0;
        logic [15:0] a1;

        rst_n = 1'b0; start = 1'b0; branch = 1'b0; branch_addr = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);

        //           addr      lo     hi     wlo whi ir        pc_after  lat
        vt[0] = '{16'h0000, 8'h34, 8'h12, 0, 0, 16'h1234, 16'h0002, 3};
        vt[1] = '{16'h0000, 8'h34, 8'h12, 3, 3, 16'h1234, 16'h0002, 9};
        vt[2] = '{16'hFFFF, 8'hAA, 8'h55, 0, 0, 16'h55AA, 16'h0001, 3};
        vt[3] = '{16'h1234, 8'hEF, 8'hBE, 1, 0, 16'hBEEF, 16'h1236, 4};
        vt[4] = '{16'h7FFE, 8'h00, 8'hFF, 0, 2, 16'hFF00, 16'h8000, 5};
        vt[5] = '{16'h00FF, 8'h5A, 8'hA5, 2, 1, 16'hA55A, 16'h0101, 6};

        // reset state
        tick;
        chk("rst_hold_ctl", {mem_rd, busy, ir_write, ir_writeu, instr_done, bus_err}, 0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("rst_ctl", {mem_rd, busy, ir_write, ir_writeu, instr_done, bus_err}, 0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_din", ir_din, 16'h0000);

        // table-driven single fetches
        for (int i = 0; i < 6; i++) begin
            a1 = vt[i].addr + 16'd1;
            mem[vt[i].addr] = vt[i].lo;
            mem[a1]         = vt[i].hi;
            wq.push_back(vt[i].wlo);
            wq.push_back(vt[i].whi);
            branch = 1'b1; branch_addr = vt[i].addr;
            tick;
            branch = 1'b0;
            w0 = nw; u0 = nwu;
            start = 1'b1;
            tick;
            start = 1'b0;
            lat = 0;
            for (int n = 1; n <= 60; n++) begin
                if (instr_done) begin lat = n; break; end
                tick;
            end
            chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
            tick;
            chk($sformatf("vec%0d_ir", i), ir_m, vt[i].ir);
            chk($sformatf("vec%0d_pc", i), pc, vt[i].pc_after);
            chk($sformatf("vec%0d_nstrb", i), {16'(nw - w0), 16'(nwu - u0)}, {16'd1, 16'd1});
        end

        // branch in the high-byte ack cycle
        mem[16'h0040] = 8'h11; mem[16'h0041] = 8'h22;
        mem[16'h0100] = 8'h77; mem[16'h0101] = 8'h66;
        wq.push_back(0); wq.push_back(0);
        branch = 1'b1; branch_addr = 16'h0040;
        tick;
        branch = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("bm_lo_addr", mem_addr, 16'h0040);
        tick;
        chk("bm_hi_addr", mem_addr, 16'h0041);
        chk("bm_lo_strobe", ir_write, 1'b1);
        u0 = nwu;
        branch = 1'b1; branch_addr = 16'h0100;
        tick;
        branch = 1'b0;
        chk("bm_rd", mem_rd, 1'b0);
        chk("bm_pc", pc, 16'h0100);
        chk("bm_busy", busy, 1'b0);
        chk("bm_no_hi", {ir_writeu, instr_done}, 0);
        tick;
        tick;
        chk("bm_nwu", nwu - u0, 0);
        wq.push_back(0); wq.push_back(0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("bm2_lo_addr", mem_addr, 16'h0100);
        tick;
        chk("bm2_hi_addr", mem_addr, 16'h0101);
        for (int n = 0; n < 20; n++) begin
            if (instr_done) break;
            tick;
        end
        tick;
        chk("bm2_ir", ir_m, 16'h6677);
        chk("bm2_pc", pc, 16'h0102);

        // timeout with the high byte withheld
        mem[16'h0200] = 8'h5C;
        wq.push_back(0); wq.push_back(100000);
        branch = 1'b1; branch_addr = 16'h0200;
        tick;
        branch = 1'b0;
        u0 = nwu; d0 = ndone;
        start = 1'b1;
        tick;
        start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            if (bus_err) begin lat = n; break; end
            tick;
        end
        chk("to_lat", lat, TMO + 3);
        chk("to_rd", mem_rd, 1'b0);
        chk("to_busy", busy, 1'b0);
        chk("to_pc", pc, 16'h0200);
        tick;
        chk("to_err_pulse", bus_err, 1'b0);
        chk("to_no_hi", {16'(nwu - u0), 16'(ndone - d0)}, 0);

        // asynchronous reset while waiting on the low byte
        wq.push_back(50);
        branch = 1'b1; branch_addr = 16'h0300;
        tick;
        branch = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("ar_pre_rd", mem_rd, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ctl", {mem_rd, busy, ir_write, ir_writeu, instr_done, bus_err}, 0);
        chk("ar_pc", pc, 16'h0000);
        chk("ar_addr", mem_addr, 16'h0000);
        chk("ar_din", ir_din, 16'h0000);
        tick;
        tick;
        rst_n = 1'b1;
        wq.delete();
        w0 = nw; u0 = nwu;
        for (int n = 0; n < 6; n++) tick;
        chk("ar_idle", {mem_rd, busy}, 0);
        chk("ar_no_strobes", (nw - w0) + (nwu - u0), 0);

        // randomized run against the model
        rnd_mode = 1'b1;
        d0 = ndone;
        for (int k = 0; k < 3000; k++) begin
            start       = ($urandom_range(0, 2) != 0);
            branch      = ($urandom_range(0, 24) == 0);
            branch_addr = ($urandom_range(0, 3) == 0) ? (16'hFFFE + 16'($urandom_range(0, 1)))
                                                      : 16'($urandom);
            tick;
        end
        rnd_mode = 1'b0; start = 1'b0; branch = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (!busy) break;
            tick;
        end
        chk("rnd_drain_busy", busy, 1'b0);
        chk("rnd_progress", (ndone - d0) > 50, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
